// File: rtl/cpu_pkg.sv
// Shared widths, opcode map and controller state encoding for the
// two-cycle accumulator machine.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_JMP = 4'h7,
    OP_JZ  = 4'h8,
    OP_LDI = 4'h9,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic opcode_e decode_op(input logic [DATA_W-1:0] instr);
    return opcode_e'(instr[DATA_W-1:ADDR_W]);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: computes the accumulator result and flags, and reports
// which architectural state the current opcode is allowed to update.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              updatesZero,
  output logic              updatesCarry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide         = '0;
    result       = a;
    carry        = 1'b0;
    updatesZero  = 1'b0;
    updatesCarry = 1'b0;
    case (opcode)
      OP_LDA, OP_LDI: begin
        result      = b;
        updatesZero = 1'b1;
      end
      OP_ADD: begin
        wide         = {1'b0, a} + {1'b0, b};
        result       = wide[DATA_W-1:0];
        carry        = wide[DATA_W];
        updatesZero  = 1'b1;
        updatesCarry = 1'b1;
      end
      // The ninth bit of the widened difference is the unsigned borrow.
      OP_SUB: begin
        wide         = {1'b0, a} - {1'b0, b};
        result       = wide[DATA_W-1:0];
        carry        = wide[DATA_W];
        updatesZero  = 1'b1;
        updatesCarry = 1'b1;
      end
      OP_AND: begin
        result      = a & b;
        updatesZero = 1'b1;
      end
      OP_OR: begin
        result      = a | b;
        updatesZero = 1'b1;
      end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/cpu_control.sv
// Fetch/execute controller: sole master of the program RAM, holding pc, ir,
// accumulator and flags, and sequencing FETCH -> EXEC until HLT.
module cpu_control
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] memReadData,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  output logic              writeEnable,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              zeroFlag,
  output logic              carryFlag,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;

  opcode_e           opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_upd_z;
  logic              alu_upd_c;
  logic              take_jump;

  assign opcode  = decode_op(ir_q);
  assign operand = ir_q[ADDR_W-1:0];

  // LDI takes its operand as an immediate instead of a memory word.
  assign alu_b = (opcode == OP_LDI) ? {{(DATA_W-ADDR_W){1'b0}}, operand} : memReadData;

  cpu_alu u_alu (
    .a            (acc_q),
    .b            (alu_b),
    .opcode       (opcode),
    .result       (alu_result),
    .carry        (alu_carry),
    .zero         (alu_zero),
    .updatesZero  (alu_upd_z),
    .updatesCarry (alu_upd_c)
  );

  assign take_jump = (opcode == OP_JMP) || ((opcode == OP_JZ) && zf_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // RAM-facing outputs; reset overrides so no write can land mid-reset.
  always_comb begin
    address     = pc_q;
    writeEnable = 1'b0;
    if (reset) begin
      address = '0;
    end else if (state_q == ST_EXEC) begin
      address     = operand;
      writeEnable = (opcode == OP_STA);
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    zf_d  = zf_q;
    cf_d  = cf_q;
    case (state_q)
      ST_FETCH: begin
        ir_d = memReadData;
        pc_d = pc_q + 4'd1;
      end
      ST_EXEC: begin
        if (alu_upd_z) begin
          acc_d = alu_result;
          zf_d  = alu_zero;
        end
        if (alu_upd_c) begin
          cf_d = alu_carry;
        end
        if (take_jump) begin
          pc_d = operand;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      zf_q  <= zf_d;
      cf_q  <= cf_d;
    end
  end

  assign dataIn    = acc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign zeroFlag  = zf_q;
  assign carryFlag = cf_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control with a behavioural 16x8 RAM attached.
module tb_cpu_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] memReadData;
  logic [3:0] address;
  logic [7:0] dataIn;
  logic       writeEnable;
  logic [7:0] acc;
  logic [3:0] pc;
  logic       zeroFlag;
  logic       carryFlag;
  logic       halted;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       load = 1'b0;

  int tests = 0;
  int fails = 0;

  cpu_control dut (
    .clock       (clock),
    .reset       (reset),
    .memReadData (memReadData),
    .address     (address),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .acc         (acc),
    .pc          (pc),
    .zeroFlag    (zeroFlag),
    .carryFlag   (carryFlag),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  assign memReadData = mem[address];

  always @(posedge clock) begin
    if (load) mem <= img;
    else if (writeEnable) mem[address] <= dataIn;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic boot();
    reset = 1'b1;
    load  = 1'b1;
    step(3);
    reset = 1'b0;
    load  = 1'b0;
  endtask

  initial begin
    // Reset with all-zero memory
    clear_img();
    load = 1'b1;
    #1;
    chk("rst_we_pre", 8'(writeEnable), 8'h00);
    chk("rst_addr_pre", 8'(address), 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_pc", 8'(pc), 8'h00);
      chk("rst_acc", acc, 8'h00);
      chk("rst_zf", 8'(zeroFlag), 8'h00);
      chk("rst_cf", 8'(carryFlag), 8'h00);
      chk("rst_we", 8'(writeEnable), 8'h00);
      chk("rst_addr", 8'(address), 8'h00);
      chk("rst_din", dataIn, 8'h00);
      chk("rst_halt", 8'(halted), 8'h00);
    end
    reset = 1'b0;
    load  = 1'b0;
    step(1);
    chk("nop_pc_fetch", 8'(pc), 8'h01);
    step(1);
    chk("nop_pc_exec", 8'(pc), 8'h01);
    chk("nop_acc", acc, 8'h00);
    step(1);
    chk("nop_pc_next", 8'(pc), 8'h02);

    // LDA 14 / ADD 15 / STA 13 / HLT
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'h2D; img[3] = 8'hF0;
    img[13] = 8'hAA; img[14] = 8'h05; img[15] = 8'h07;
    boot();
    step(2);
    chk("lda_acc", acc, 8'h05);
    step(2);
    chk("add_acc", acc, 8'h0C);
    chk("add_zf", 8'(zeroFlag), 8'h00);
    chk("add_cf", 8'(carryFlag), 8'h00);
    step(1);
    chk("sta_we", 8'(writeEnable), 8'h01);
    chk("sta_addr", 8'(address), 8'h0D);
    chk("sta_din", dataIn, 8'h0C);
    chk("sta_mem_before", mem[13], 8'hAA);
    step(1);
    chk("sta_mem_after", mem[13], 8'h0C);
    chk("sta_we_off", 8'(writeEnable), 8'h00);
    step(2);
    chk("hlt_halted", 8'(halted), 8'h01);
    chk("hlt_pc", 8'(pc), 8'h04);
    step(3);
    chk("hlt_hold_pc", 8'(pc), 8'h04);
    chk("hlt_hold_halt", 8'(halted), 8'h01);
    chk("hlt_hold_acc", acc, 8'h0C);
    chk("hlt_hold_we", 8'(writeEnable), 8'h00);
    chk("hlt_addr", 8'(address), 8'h04);

    // Carry / borrow / AND-to-zero
    clear_img();
    img[0] = 8'h9F; img[1] = 8'h3E; img[2] = 8'h4D; img[3] = 8'h5C; img[4] = 8'hF0;
    img[12] = 8'h00; img[13] = 8'h05; img[14] = 8'hF5;
    boot();
    step(2);
    chk("ldi_acc", acc, 8'h0F);
    step(2);
    chk("addc_acc", acc, 8'h04);
    chk("addc_cf", 8'(carryFlag), 8'h01);
    chk("addc_zf", 8'(zeroFlag), 8'h00);
    step(2);
    chk("subb_acc", acc, 8'hFF);
    chk("subb_cf", 8'(carryFlag), 8'h01);
    chk("subb_zf", 8'(zeroFlag), 8'h00);
    step(2);
    chk("and_acc", acc, 8'h00);
    chk("and_zf", 8'(zeroFlag), 8'h01);
    chk("and_cf_hold", 8'(carryFlag), 8'h01);
    step(2);
    chk("hlt2_halted", 8'(halted), 8'h01);
    chk("hlt2_pc", 8'(pc), 8'h05);

    // JZ taken
    clear_img();
    img[0] = 8'h90; img[1] = 8'h86; img[6] = 8'hF0;
    boot();
    step(2);
    chk("jz_ldi0_zf", 8'(zeroFlag), 8'h01);
    step(2);
    chk("jz_taken_pc", 8'(pc), 8'h06);
    step(2);
    chk("jz_hlt_halted", 8'(halted), 8'h01);
    chk("jz_hlt_pc", 8'(pc), 8'h07);

    // JZ not taken, OR, JMP-to-self loop
    clear_img();
    img[0] = 8'h91; img[1] = 8'h86; img[2] = 8'h6D; img[3] = 8'h73; img[13] = 8'h80;
    boot();
    step(4);
    chk("jz_fall_pc", 8'(pc), 8'h02);
    step(2);
    chk("or_acc", acc, 8'h81);
    chk("or_zf", 8'(zeroFlag), 8'h00);
    step(1);
    chk("jmp_fetch_pc", 8'(pc), 8'h04);
    step(1);
    chk("jmp_pc", 8'(pc), 8'h03);
    step(4);
    chk("jmp_loop_pc", 8'(pc), 8'h03);
    chk("jmp_loop_halt", 8'(halted), 8'h00);

    // Reset during STA execute
    clear_img();
    img[0] = 8'h9A; img[1] = 8'h2D; img[13] = 8'h33;
    boot();
    step(3);
    reset = 1'b1;
    #1;
    chk("rsta_we", 8'(writeEnable), 8'h00);
    chk("rsta_addr", 8'(address), 8'h00);
    step(1);
    reset = 1'b0;
    chk("rsta_mem", mem[13], 8'h33);
    chk("rsta_pc", 8'(pc), 8'h00);
    chk("rsta_acc", acc, 8'h00);
    step(1);
    chk("rsta_refetch_pc", 8'(pc), 8'h01);

    // PC wrap with opcode B at address 15
    clear_img();
    img[0] = 8'h95; img[15] = 8'hB3;
    boot();
    step(30);
    chk("wrap_pre_pc", 8'(pc), 8'h0F);
    step(1);
    chk("wrap_pc", 8'(pc), 8'h00);
    chk("opb_we", 8'(writeEnable), 8'h00);
    chk("opb_addr", 8'(address), 8'h03);
    step(1);
    chk("opb_pc", 8'(pc), 8'h00);
    chk("opb_acc", acc, 8'h05);
    chk("opb_zf", 8'(zeroFlag), 8'h00);
    chk("opb_cf", 8'(carryFlag), 8'h00);
    chk("opb_mem3", mem[3], 8'h00);
    step(2);
    chk("wrap_refetch_pc", 8'(pc), 8'h01);
    chk("wrap_halt", 8'(halted), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
